// File: rtl/memory_interface.sv
`default_nettype none
// ============================================================================
// memory_interface: MAR/MDR owner that runs read/write transactions against
// a synchronous RAM with a configurable read latency.
// Revision: 1.0
// ============================================================================
module memory_interface #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] BusMuxOut,
    input  logic                  MARin,
    input  logic                  MDRin,
    input  logic                  read,
    input  logic                  wren,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] MDRdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic                  busy,
    output logic                  done
);

    // A latency of 0 behaves as 1; the 3-bit counter caps it at 7.
    localparam int          c_WAIT_CLAMP = (WAIT_CYCLES < 1) ? 1 :
                                           ((WAIT_CYCLES > 7) ? 7 : WAIT_CYCLES);
    localparam logic [2:0]  c_WAIT_INIT  = 3'(c_WAIT_CLAMP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [2:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   mar_q;
    logic [DATA_WIDTH-1:0]   mdr_q;
    logic                    done_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            mar_q   <= '0;
            mdr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (MARin)
                        mar_q <= BusMuxOut[ADDR_WIDTH-1:0];
                    if (MDRin && !read)
                        mdr_q <= BusMuxOut;
                    // A read request beats a simultaneous write; the write is dropped.
                    if (MDRin && read) begin
                        state_q <= S_READ;
                        cnt_q   <= c_WAIT_INIT;
                    end else if (wren) begin
                        state_q <= S_WRITE;
                    end
                end
                S_READ: begin
                    if (cnt_q <= 3'd1) begin
                        mdr_q   <= mem_rdata;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                S_WRITE: begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign MDRdata   = mdr_q;
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;
    assign mem_re    = (state_q == S_READ);
    assign mem_we    = (state_q == S_WRITE);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

    // Only the low ADDR_WIDTH bus bits address the RAM.
    if (DATA_WIDTH > ADDR_WIDTH) begin : g_unused_bus
        logic unused_bus;
        assign unused_bus = ^BusMuxOut[DATA_WIDTH-1:ADDR_WIDTH];
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_interface.sv
`default_nettype none
// ============================================================================
// tb_memory_interface: directed, table-driven bench for memory_interface.
// Revision: 1.0
// ============================================================================
module tb_memory_interface;

    logic        clk;
    logic        Reset;
    logic        rst3_n;
    logic [31:0] BusMuxOut;
    logic        MARin, MDRin, read, wren;

    logic [31:0] mem_rdata, MDRdata, mem_wdata;
    logic [8:0]  mem_addr;
    logic        mem_re, mem_we, busy, done;

    logic [31:0] rdata3, mdr3, wdata3;
    logic [8:0]  addr3;
    logic        re3, we3, busy3, done3;

    logic [31:0] ram [0:511] = '{default: 32'h0};

    int n_checks = 0;
    int n_fail   = 0;

    memory_interface #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_CYCLES(2)) dut (
        .Clock(clk), .Reset(Reset), .BusMuxOut(BusMuxOut),
        .MARin(MARin), .MDRin(MDRin), .read(read), .wren(wren),
        .mem_rdata(mem_rdata), .MDRdata(MDRdata), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .busy(busy), .done(done)
    );

    memory_interface #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_CYCLES(3)) dut3 (
        .Clock(clk), .Reset(rst3_n), .BusMuxOut(BusMuxOut),
        .MARin(MARin), .MDRin(MDRin), .read(read), .wren(wren),
        .mem_rdata(rdata3), .MDRdata(mdr3), .mem_addr(addr3),
        .mem_wdata(wdata3), .mem_re(re3), .mem_we(we3),
        .busy(busy3), .done(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: combinational read port, write on rising edge.
    assign mem_rdata = ram[mem_addr];
    assign rdata3    = ram[addr3];

    always @(posedge clk) begin
        if (!Reset) begin
            ram[9'h005] <= 32'h0000_1234;
            ram[9'h01F] <= 32'h0000_0000;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    typedef struct {
        logic        marin, mdrin, rd, wr;
        logic [31:0] bus;
        logic [31:0] e_mdr;
        logic [8:0]  e_addr;
        logic        e_busy, e_done, e_re, e_we;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(input logic [3:0] ctl, input logic [31:0] bus,
                                input logic [31:0] mdr, input logic [8:0] addr,
                                input logic [3:0] st);
        vec_t v;
        {v.marin, v.mdrin, v.rd, v.wr} = ctl;
        v.bus    = bus;
        v.e_mdr  = mdr;
        v.e_addr = addr;
        {v.e_busy, v.e_done, v.e_re, v.e_we} = st;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic m, input logic d, input logic r, input logic w,
                         input logic [31:0] bus);
        MARin = m; MDRin = d; read = r; wren = w; BusMuxOut = bus;
    endtask

    initial begin
        // ctl = {MARin, MDRin, read, wren}; st = {busy, done, mem_re, mem_we}
        vecs[0]  = mk(4'b0000, 32'h0,         32'h0,         9'h000, 4'b0000);
        vecs[1]  = mk(4'b1000, 32'h5,         32'h0,         9'h005, 4'b0000);
        vecs[2]  = mk(4'b0110, 32'h0,         32'h0,         9'h005, 4'b1010);
        vecs[3]  = mk(4'b0000, 32'h0,         32'h0,         9'h005, 4'b1010);
        vecs[4]  = mk(4'b0000, 32'h0,         32'h0000_1234, 9'h005, 4'b0100);
        vecs[5]  = mk(4'b0000, 32'h0,         32'h0000_1234, 9'h005, 4'b0000);
        vecs[6]  = mk(4'b1000, 32'h1F,        32'h0000_1234, 9'h01F, 4'b0000);
        vecs[7]  = mk(4'b0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 9'h01F, 4'b0000);
        vecs[8]  = mk(4'b0001, 32'h0,         32'hDEAD_BEEF, 9'h01F, 4'b1001);
        vecs[9]  = mk(4'b0000, 32'h0,         32'hDEAD_BEEF, 9'h01F, 4'b0100);
        vecs[10] = mk(4'b1000, 32'h5,         32'hDEAD_BEEF, 9'h005, 4'b0000);
        vecs[11] = mk(4'b0111, 32'h0,         32'hDEAD_BEEF, 9'h005, 4'b1010);
        vecs[12] = mk(4'b1101, 32'h7,         32'hDEAD_BEEF, 9'h005, 4'b1010);
        vecs[13] = mk(4'b0000, 32'h0,         32'h0000_1234, 9'h005, 4'b0100);
        vecs[14] = mk(4'b0100, 32'hCAFE_F00D, 32'hCAFE_F00D, 9'h005, 4'b0000);
        vecs[15] = mk(4'b0110, 32'h0,         32'hCAFE_F00D, 9'h005, 4'b1010);
        vecs[16] = mk(4'b0000, 32'h0,         32'hCAFE_F00D, 9'h005, 4'b1010);
        vecs[17] = mk(4'b0000, 32'h0,         32'h0000_1234, 9'h005, 4'b0100);
        vecs[18] = mk(4'b0000, 32'h0,         32'h0000_1234, 9'h005, 4'b0000);

        Reset  = 1'b0;
        rst3_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_mdr",  MDRdata,  32'h0);
        check("rst_addr", {23'h0, mem_addr}, 32'h0);
        check("rst_busy", {31'h0, busy},   32'h0);
        check("rst_done", {31'h0, done},   32'h0);
        check("rst_re",   {31'h0, mem_re}, 32'h0);
        check("rst_we",   {31'h0, mem_we}, 32'h0);
        @(negedge clk);
        Reset = 1'b1;

        // Table: one vector per cycle, inputs at negedge, outputs after the edge
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(vecs[i].marin, vecs[i].mdrin, vecs[i].rd, vecs[i].wr, vecs[i].bus);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_mdr", i),   MDRdata,            vecs[i].e_mdr);
            check($sformatf("v%0d_wdata", i), mem_wdata,          vecs[i].e_mdr);
            check($sformatf("v%0d_addr", i),  {23'h0, mem_addr},  {23'h0, vecs[i].e_addr});
            check($sformatf("v%0d_busy", i),  {31'h0, busy},      {31'h0, vecs[i].e_busy});
            check($sformatf("v%0d_done", i),  {31'h0, done},      {31'h0, vecs[i].e_done});
            check($sformatf("v%0d_re", i),    {31'h0, mem_re},    {31'h0, vecs[i].e_re});
            check($sformatf("v%0d_we", i),    {31'h0, mem_we},    {31'h0, vecs[i].e_we});
        end
        check("ram_1F_readback", ram[9'h01F], 32'hDEAD_BEEF);

        // Asynchronous reset in the middle of a write drops mem_we at once
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        @(posedge clk);
        #1;
        check("wrst_we_before", {31'h0, mem_we}, 32'h1);
        #1;
        Reset = 1'b0;
        #1;
        check("wrst_we",   {31'h0, mem_we}, 32'h0);
        check("wrst_busy", {31'h0, busy},   32'h0);
        check("wrst_mdr",  MDRdata,         32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        Reset = 1'b1;
        @(posedge clk);
        #1;
        check("wrst_done", {31'h0, done}, 32'h0);

        // Reset during cycle k+1 of a WAIT_CYCLES=3 read
        @(negedge clk);
        rst3_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h5);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        check("r3_busy_k", {31'h0, busy3}, 32'h1);
        check("r3_re_k",   {31'h0, re3},   32'h1);
        check("r3_addr_k", {23'h0, addr3}, 32'h5);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        check("r3_busy_k1", {31'h0, busy3}, 32'h1);
        #2;
        rst3_n = 1'b0;
        #1;
        check("r3_rst_busy", {31'h0, busy3}, 32'h0);
        check("r3_rst_re",   {31'h0, re3},   32'h0);
        check("r3_rst_mdr",  mdr3,           32'h0);
        check("r3_rst_addr", {23'h0, addr3}, 32'h0);
        @(negedge clk);
        rst3_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("r3_post%0d_done", c), {31'h0, done3}, 32'h0);
            check($sformatf("r3_post%0d_mdr", c),  mdr3,           32'h0);
        end
        check("r3_idle_busy", {31'h0, busy3}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
